// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter FSM: idle, fetch transaction on the bus, data transaction on the bus.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2
    } arb_state_t;

    // Which port received the most recent bus grant.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Round-robin tie break: the fetch port wins a tie only if data went last.
    function automatic logic tie_goes_to_i(input grant_t last);
        return (last == GRANT_D);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_timeout.sv
// Wait-cycle counter for one bus transaction. o_expired marks the
// TIMEOUT-th consecutive waiting cycle; TIMEOUT = 0 never expires.
module mem_port_arbiter_bus_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] r_cnt;

    // Count waiting cycles; cleared whenever no transaction is active.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (TIMEOUT != 0) && i_enable && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between the fetch (F) and data (M)
// ports, one transaction in flight. Acks are combinational from registered
// done flags; done flags hold while the owning stage is stalled so a
// completed access is never re-issued.
//
// Bus handshake: busreq rises the cycle after a grant and stays high with
// busadr/buswrite/busbe/buswdata stable until a cycle where busready=1 (or
// the wait counter expires); that cycle completes the transaction and
// busreq is low on the next cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instrreqF,
    input  logic [AW-1:0]   instradrF,
    input  logic            stallF,
    output logic [DW-1:0]   instrF,
    output logic            instrackF,
    output logic            instrerrF,
    input  logic            datareqM,
    input  logic            memwriteM,
    input  logic [AW-1:0]   dataadrM,
    input  logic [DW/8-1:0] byteenM,
    input  logic [DW-1:0]   writedataM,
    input  logic            stallM,
    output logic [DW-1:0]   readdataM,
    output logic            dataackM,
    output logic            dataerrM,
    output logic            busreq,
    output logic            buswrite,
    output logic [AW-1:0]   busadr,
    output logic [DW/8-1:0] busbe,
    output logic [DW-1:0]   buswdata,
    input  logic [DW-1:0]   busrdata,
    input  logic            busready,
    output logic [1:0]      o_dbg_state
);

    arb_state_t      r_state, w_state_nxt;
    grant_t          r_last, w_last_nxt;
    logic            r_idone, w_idone_nxt;
    logic            r_ddone, w_ddone_nxt;
    logic            r_ierr, w_ierr_nxt;
    logic            r_derr, w_derr_nxt;
    logic [DW-1:0]   r_instr, w_instr_nxt;
    logic [DW-1:0]   r_rdata, w_rdata_nxt;
    logic [AW-1:0]   r_adr, w_adr_nxt;
    logic            r_write, w_write_nxt;
    logic [DW/8-1:0] r_be, w_be_nxt;
    logic [DW-1:0]   r_wdata, w_wdata_nxt;

    logic            w_ipend, w_dpend;
    logic            w_bus_active, w_wait, w_expired, w_end, w_timeout;
    logic            w_i_match, w_d_match;
    logic [DW-1:0]   w_end_data;

    assign w_ipend      = instrreqF & ~r_idone;
    assign w_dpend      = datareqM & ~r_ddone;
    assign w_bus_active = (r_state != ST_IDLE);
    assign w_wait       = w_bus_active & ~busready;
    assign w_end        = w_bus_active & (busready | w_expired);
    assign w_timeout    = ~busready & w_expired;
    assign w_end_data   = busready ? busrdata : '0;
    // A result is kept only if the requester still wants the latched access.
    assign w_i_match    = instrreqF && (instradrF == r_adr);
    assign w_d_match    = datareqM && (dataadrM == r_adr) && (memwriteM == r_write);

    mem_port_arbiter_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state == ST_IDLE),
        .i_enable  (w_wait),
        .o_expired (w_expired)
    );

    // Next-state, grant, completion and done-flag bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_idone_nxt = r_idone;
        w_ddone_nxt = r_ddone;
        w_ierr_nxt  = r_ierr;
        w_derr_nxt  = r_derr;
        w_instr_nxt = r_instr;
        w_rdata_nxt = r_rdata;
        w_adr_nxt   = r_adr;
        w_write_nxt = r_write;
        w_be_nxt    = r_be;
        w_wdata_nxt = r_wdata;

        // Release a done flag once its stage advances or withdraws the request.
        if (r_idone && (!stallF || !instrreqF)) begin
            w_idone_nxt = 1'b0;
            w_ierr_nxt  = 1'b0;
        end
        if (r_ddone && (!stallM || !datareqM)) begin
            w_ddone_nxt = 1'b0;
            w_derr_nxt  = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_ipend && (!w_dpend || tie_goes_to_i(r_last))) begin
                    w_state_nxt = ST_IBUS;
                    w_last_nxt  = GRANT_I;
                    w_adr_nxt   = instradrF;
                    w_write_nxt = 1'b0;
                    w_be_nxt    = '1;
                    w_wdata_nxt = '0;
                end else if (w_dpend) begin
                    w_state_nxt = ST_DBUS;
                    w_last_nxt  = GRANT_D;
                    w_adr_nxt   = dataadrM;
                    w_write_nxt = memwriteM;
                    w_be_nxt    = memwriteM ? byteenM : '1;
                    w_wdata_nxt = memwriteM ? writedataM : '0;
                end
            end
            ST_IBUS: begin
                if (w_end) begin
                    w_state_nxt = ST_IDLE;
                    if (w_i_match) begin
                        w_idone_nxt = 1'b1;
                        w_ierr_nxt  = w_timeout;
                        w_instr_nxt = w_end_data;
                    end
                end
            end
            ST_DBUS: begin
                if (w_end) begin
                    w_state_nxt = ST_IDLE;
                    w_write_nxt = 1'b0;
                    if (w_d_match) begin
                        w_ddone_nxt = 1'b1;
                        w_derr_nxt  = w_timeout;
                        if (!r_write) begin
                            w_rdata_nxt = w_end_data;
                        end else begin
                            // A store may alias the fetched line: force a refetch.
                            w_idone_nxt = 1'b0;
                            w_ierr_nxt  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= GRANT_I;
            r_idone <= 1'b0;
            r_ddone <= 1'b0;
            r_ierr  <= 1'b0;
            r_derr  <= 1'b0;
            r_instr <= '0;
            r_rdata <= '0;
            r_adr   <= '0;
            r_write <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_idone <= w_idone_nxt;
            r_ddone <= w_ddone_nxt;
            r_ierr  <= w_ierr_nxt;
            r_derr  <= w_derr_nxt;
            r_instr <= w_instr_nxt;
            r_rdata <= w_rdata_nxt;
            r_adr   <= w_adr_nxt;
            r_write <= w_write_nxt;
            r_be    <= w_be_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    assign instrackF   = ~instrreqF | r_idone;
    assign dataackM    = ~datareqM | r_ddone;
    assign instrF      = r_instr;
    assign readdataM   = r_rdata;
    assign instrerrF   = r_ierr;
    assign dataerrM    = r_derr;
    assign busreq      = w_bus_active;
    assign buswrite    = r_write;
    assign busadr      = r_adr;
    assign busbe       = r_be;
    assign buswdata    = r_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, round-robin ties, store with
// stalled stage and refetch, timeout, discarded result, reset mid-transfer.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instrreqF;
    logic [31:0] instradrF;
    logic        stallF;
    logic [31:0] instrF;
    logic        instrackF;
    logic        instrerrF;
    logic        datareqM;
    logic        memwriteM;
    logic [31:0] dataadrM;
    logic [3:0]  byteenM;
    logic [31:0] writedataM;
    logic        stallM;
    logic [31:0] readdataM;
    logic        dataackM;
    logic        dataerrM;
    logic        busreq;
    logic        buswrite;
    logic [31:0] busadr;
    logic [3:0]  busbe;
    logic [31:0] buswdata;
    logic [31:0] busrdata;
    logic        busready;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instrreqF   (instrreqF),
        .instradrF   (instradrF),
        .stallF      (stallF),
        .instrF      (instrF),
        .instrackF   (instrackF),
        .instrerrF   (instrerrF),
        .datareqM    (datareqM),
        .memwriteM   (memwriteM),
        .dataadrM    (dataadrM),
        .byteenM     (byteenM),
        .writedataM  (writedataM),
        .stallM      (stallM),
        .readdataM   (readdataM),
        .dataackM    (dataackM),
        .dataerrM    (dataerrM),
        .busreq      (busreq),
        .buswrite    (buswrite),
        .busadr      (busadr),
        .busbe       (busbe),
        .buswdata    (buswdata),
        .busrdata    (busrdata),
        .busready    (busready),
        .o_dbg_state (dbg_state)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Bus slave: n_wait cycles with busready low, then one ready cycle.
    // Returns just after the edge that completes the transaction.
    task automatic serve(input int n_wait, input logic [31:0] rdata);
        for (int i = 0; i < n_wait; i++) begin
            busready = 1'b0;
            cyc();
        end
        busready = 1'b1;
        busrdata = rdata;
        cyc();
        busready = 1'b0;
        busrdata = '0;
    endtask

    initial begin
        reset      = 1'b1;
        instrreqF  = 1'b0;
        instradrF  = '0;
        stallF     = 1'b0;
        datareqM   = 1'b0;
        memwriteM  = 1'b0;
        dataadrM   = '0;
        byteenM    = '0;
        writedataM = '0;
        stallM     = 1'b0;
        busrdata   = '0;
        busready   = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_busreq", 32'(busreq), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        check_eq("rst_iack", 32'(instrackF), 32'd1);
        check_eq("rst_dack", 32'(dataackM), 32'd1);
        check_eq("rst_instr", instrF, 32'h0);
        check_eq("rst_busadr", busadr, 32'h0);

        // 1: fetch only, busready two cycles after the grant
        cyc();
        instrreqF = 1'b1;
        instradrF = 32'h100;
        @(negedge clk);
        check_eq("t1_iack_pending", 32'(instrackF), 32'd0);
        cyc();
        @(negedge clk);
        check_eq("t1_busreq", 32'(busreq), 32'd1);
        check_eq("t1_busadr", busadr, 32'h100);
        check_eq("t1_busbe", 32'(busbe), 32'hF);
        check_eq("t1_buswrite", 32'(buswrite), 32'd0);
        serve(1, 32'h2402_000A);
        @(negedge clk);
        check_eq("t1_iack", 32'(instrackF), 32'd1);
        check_eq("t1_instr", instrF, 32'h2402_000A);
        check_eq("t1_ierr", 32'(instrerrF), 32'd0);
        check_eq("t1_busreq_drop", 32'(busreq), 32'd0);
        cyc();
        instrreqF = 1'b0;

        // 2: tie after reset goes to D, then I; a later tie after D goes to I
        cyc();
        instrreqF = 1'b1;
        instradrF = 32'h300;
        stallF    = 1'b1;
        datareqM  = 1'b1;
        memwriteM = 1'b0;
        dataadrM  = 32'h400;
        stallM    = 1'b1;
        @(negedge clk);
        check_eq("t2_both_pending", 32'({instrackF, dataackM}), 32'd0);
        cyc();
        @(negedge clk);
        check_eq("t2_first_state", 32'(dbg_state), 32'd2);
        check_eq("t2_first_adr", busadr, 32'h400);
        serve(1, 32'hDDDD_0001);
        @(negedge clk);
        check_eq("t2_dack", 32'(dataackM), 32'd1);
        check_eq("t2_rdata", readdataM, 32'hDDDD_0001);
        cyc();
        @(negedge clk);
        check_eq("t2_second_state", 32'(dbg_state), 32'd1);
        check_eq("t2_second_adr", busadr, 32'h300);
        serve(0, 32'h1111_0003);
        instrreqF = 1'b0;
        datareqM  = 1'b0;
        stallF    = 1'b0;
        stallM    = 1'b0;
        @(negedge clk);
        check_eq("t2_instr", instrF, 32'h1111_0003);
        cyc();
        datareqM = 1'b1;
        dataadrM = 32'h404;
        cyc();
        @(negedge clk);
        check_eq("t2_donly_adr", busadr, 32'h404);
        serve(0, 32'h0000_0005);
        datareqM = 1'b0;
        @(negedge clk);
        check_eq("t2_donly_rdata", readdataM, 32'h5);
        cyc();
        instrreqF = 1'b1;
        instradrF = 32'h500;
        datareqM  = 1'b1;
        dataadrM  = 32'h600;
        cyc();
        @(negedge clk);
        check_eq("t2_tie2_state", 32'(dbg_state), 32'd1);
        check_eq("t2_tie2_adr", busadr, 32'h500);
        serve(0, 32'h0000_0007);
        instrreqF = 1'b0;
        datareqM  = 1'b0;
        @(negedge clk);
        check_eq("t2_tie2_instr", instrF, 32'h7);

        // 3: held fetch, store clears it (refetch), stalled store not re-issued, then load
        cyc();
        instrreqF = 1'b1;
        instradrF = 32'h700;
        stallF    = 1'b1;
        cyc();
        serve(0, 32'h0000_0099);
        datareqM   = 1'b1;
        memwriteM  = 1'b1;
        dataadrM   = 32'h200;
        byteenM    = 4'b0011;
        writedataM = 32'hAABB_CCDD;
        stallM     = 1'b1;
        @(negedge clk);
        check_eq("t3_iack_held", 32'(instrackF), 32'd1);
        check_eq("t3_instr", instrF, 32'h99);
        cyc();
        @(negedge clk);
        check_eq("t3_st_write", 32'(buswrite), 32'd1);
        check_eq("t3_st_be", 32'(busbe), 32'h3);
        check_eq("t3_st_adr", busadr, 32'h200);
        check_eq("t3_st_wdata", buswdata, 32'hAABB_CCDD);
        serve(1, 32'hDEAD_BEEF);
        @(negedge clk);
        check_eq("t3_st_dack", 32'(dataackM), 32'd1);
        check_eq("t3_st_rdata_kept", readdataM, 32'h5);
        check_eq("t3_refetch_needed", 32'(instrackF), 32'd0);
        cyc();
        @(negedge clk);
        check_eq("t3_refetch_state", 32'(dbg_state), 32'd1);
        check_eq("t3_refetch_adr", busadr, 32'h700);
        check_eq("t3_dack_stall1", 32'(dataackM), 32'd1);
        serve(0, 32'h0000_009A);
        @(negedge clk);
        check_eq("t3_refetch_instr", instrF, 32'h9A);
        check_eq("t3_dack_stall2", 32'(dataackM), 32'd1);
        check_eq("t3_busreq_idle1", 32'(busreq), 32'd0);
        cyc();
        @(negedge clk);
        check_eq("t3_busreq_idle2", 32'(busreq), 32'd0);
        check_eq("t3_dack_stall3", 32'(dataackM), 32'd1);
        cyc();
        stallM    = 1'b0;
        stallF    = 1'b0;
        instrreqF = 1'b0;
        @(negedge clk);
        check_eq("t3_dack_advance", 32'(dataackM), 32'd1);
        cyc();
        memwriteM = 1'b0;
        dataadrM  = 32'h204;
        @(negedge clk);
        check_eq("t3_ddone_cleared", 32'(dataackM), 32'd0);
        cyc();
        @(negedge clk);
        check_eq("t3_ld_adr", busadr, 32'h204);
        check_eq("t3_ld_be", 32'(busbe), 32'hF);
        check_eq("t3_ld_write", 32'(buswrite), 32'd0);
        serve(0, 32'h1234_5678);
        datareqM = 1'b0;
        @(negedge clk);
        check_eq("t3_ld_rdata", readdataM, 32'h1234_5678);

        // 4: timeout after four waiting cycles
        cyc();
        datareqM = 1'b1;
        dataadrM = 32'h800;
        stallM   = 1'b1;
        @(negedge clk);
        check_eq("t4_dack_pending", 32'(dataackM), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            check_eq($sformatf("t4_busreq_wait%0d", i + 1), 32'(busreq), 32'd1);
        end
        cyc();
        @(negedge clk);
        check_eq("t4_busreq_drop", 32'(busreq), 32'd0);
        check_eq("t4_derr", 32'(dataerrM), 32'd1);
        check_eq("t4_rdata_zero", readdataM, 32'h0);
        check_eq("t4_dack", 32'(dataackM), 32'd1);
        check_eq("t4_state", 32'(dbg_state), 32'd0);
        cyc();
        datareqM = 1'b0;
        stallM   = 1'b0;
        @(negedge clk);
        check_eq("t4_derr_held", 32'(dataerrM), 32'd1);
        cyc();
        @(negedge clk);
        check_eq("t4_derr_clear", 32'(dataerrM), 32'd0);

        // 6: fetch withdrawn mid-transaction, result discarded
        instrreqF = 1'b1;
        instradrF = 32'hA00;
        cyc();
        instrreqF = 1'b0;
        cyc();
        busready = 1'b1;
        busrdata = 32'hFFFF_0000;
        cyc();
        busready = 1'b0;
        busrdata = '0;
        @(negedge clk);
        check_eq("t6_instr_kept", instrF, 32'h9A);
        check_eq("t6_busreq", 32'(busreq), 32'd0);
        cyc();
        instrreqF = 1'b1;
        @(negedge clk);
        check_eq("t6_no_idone", 32'(instrackF), 32'd0);
        cyc();
        serve(0, 32'h0000_A0A0);
        instrreqF = 1'b0;
        @(negedge clk);
        check_eq("t6_refetch_instr", instrF, 32'hA0A0);

        // 5: reset during a data transaction
        cyc();
        datareqM  = 1'b1;
        memwriteM = 1'b0;
        dataadrM  = 32'h900;
        cyc();
        @(negedge clk);
        check_eq("t5_busreq", 32'(busreq), 32'd1);
        check_eq("t5_state", 32'(dbg_state), 32'd2);
        cyc();
        reset = 1'b1;
        cyc();
        @(negedge clk);
        check_eq("t5_busreq_drop", 32'(busreq), 32'd0);
        check_eq("t5_state_idle", 32'(dbg_state), 32'd0);
        check_eq("t5_dack", 32'(dataackM), 32'd0);
        check_eq("t5_iack", 32'(instrackF), 32'd1);
        check_eq("t5_errs", 32'({instrerrF, dataerrM}), 32'd0);
        check_eq("t5_instr", instrF, 32'h0);
        reset    = 1'b0;
        datareqM = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
